alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined ARM data-processing ALU; successor to the single-cycle datapath ALU.
//  Native two's-complement arithmetic, true carry/borrow, ADC/SBC/RSC, S-bit gated NZCV register.
//  valid/ready handshake on both sides. Sits between the decode/register-read stage and writeback.
// PARAMETERS
//  WIDTH       32       datapath width (>=8)
//  TAG_W       4        destination-register tag, carried alongside the result
//  FLAG_RESET  4'b0000  reset value of the flags register
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  flush        in   1      sync: drop both stages; flags register unchanged
//  in_valid     in   1      operation offered
//  in_ready     out  1      operation accepted when in_valid&in_ready
//  in_op        in   5      opcode, same encoding as the existing ALU (00000 AND .. 01111 MVN)
//  in_a,in_b    in   WIDTH  operand 1 (Rn), operand 2 (shifter output)
//  in_set_flags in   1      S bit
//  in_shift_c   in   1      shifter carry-out, used as C for logical ops
//  in_tag       in   TAG_W  destination tag
//  out_valid    out  1      result available
//  out_ready    in   1      result consumed when out_valid&out_ready
//  out_result   out  WIDTH  result
//  out_wb       out  1      1 = write result back (0 for TST/TEQ/CMP/CMN/illegal)
//  out_tag      out  TAG_W  tag of out_result
//  out_illegal  out  1      opcode 1xxxx
//  flags        out  4      live NZCV register: [0]=Z [1]=C [2]=N [3]=V
// BEHAVIOUR
//  Reset: in_ready=1 after release; out_valid=0, out_result=0, out_wb=0, out_tag=0, out_illegal=0, flags=FLAG_RESET.
//  Stage A: input register (valid_a). Stage B: core computes from stage A, captured into output register.
//  Accept at edge k -> out_valid at edge k+1, i.e. 2-cycle latency; throughput 1 op/cycle.
//  adv_b = !out_valid | out_ready; adv_a = adv_b; in_ready = !valid_a | adv_a. Full stall when out held.
//  Flags register written at the stage A->B edge (adv_b & valid_a & upd). Every older op has then already updated C.
//  ADC/SBC/RSC read carry from the flags register directly; no forwarding is needed.
//  Arithmetic: WIDTH+1-bit sum; SUB = a+~b+1, RSB = b+~a+1, ADC = a+b+C, SBC = a+~b+C, RSC = b+~a+C.
//  Arithmetic flags: C = bit WIDTH of the sum (SUB: C=1 means no borrow); V = signed overflow of the adder operands.
//   N = result[WIDTH-1]; Z = (result==0).
//  Logical (AND EOR TST TEQ ORR MOV BIC MVN): C = in_shift_c, V unchanged, N and Z from result.
//  upd = in_set_flags for writing ops; upd = 1 for TST/TEQ/CMP/CMN regardless of S.
//  Illegal 1xxxx: result 0, out_wb=0, out_illegal=1, flags unchanged, op still flows through the pipe.
//  flush: valid_a and out_valid clear on the next edge. An op in A is discarded without updating flags.
//   flush beats simultaneous in_valid; in_ready unaffected.
//  Reset mid-operation: all in-flight ops lost, flags return to FLAG_RESET.
//  Outputs hold stable while out_valid & !out_ready. Payload registers load only on adv.
// STRUCTURE
//  Package alu_pkg: opcode localparams (OP_AND..OP_MVN), flag index constants FLG_Z/C/N/V.
//   Also an is_test(op) function and an is_arith(op) function.
//  Sub-module alu_core (combinational): op, a, b, c_in, shift_c -> result, nzcv, upd_mask, wb, illegal.
//  alu_pipe: handshake, stage registers, flags register.
// TESTING
//  ADD 7 + 0xFFFFFFF9, S=1 -> result 0, flags Z=1 C=1 N=0 V=0, out_wb=1, after 2 cycles.
//  SUB 0x80000000 - 1, S=1 -> 0x7FFFFFFF, V=1 C=1 N=0. Then CMP 3,7 -> wb=0, N=1 C=0.
//  Back-to-back ADDS 0xFFFFFFFF+1 then ADC 5+5 -> second result 11; carry from the older op is used.
//  out_ready low for 5 cycles with 3 ops sent -> in_ready drops after 2 accepted, outputs stable, no loss/dup.
//   Order preserved by tag.
//  ANDS with in_shift_c=1 -> C=1, V unchanged. ADD with S=0 -> flags unchanged.
//  flush while 2 ops in flight -> no out_valid, flags unchanged. Opcode 10110 -> out_illegal=1, wb=0.
//  Async reset asserted mid-stream -> outputs zero immediately, flags=FLAG_RESET.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ARM ALU.
// Imported by alu_core and alu_pipe.
package alu_pkg;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_EOR = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_RSB = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SBC = 5'b00110;
    localparam logic [4:0] OP_RSC = 5'b00111;
    localparam logic [4:0] OP_TST = 5'b01000;
    localparam logic [4:0] OP_TEQ = 5'b01001;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_CMN = 5'b01011;
    localparam logic [4:0] OP_ORR = 5'b01100;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam logic [4:0] OP_BIC = 5'b01110;
    localparam logic [4:0] OP_MVN = 5'b01111;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    function automatic logic is_test(input logic [4:0] op);
        return op[4:2] == 3'b010;
    endfunction

    // SUB..RSC plus CMP/CMN go through the adder
    function automatic logic is_arith(input logic [4:0] op);
        return !op[4] &&
               ((!op[3] && op[2:1] != 2'b00) || op[3:1] == 3'b101);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ARM data-processing core.
// Produces result, candidate NZCV and the mask of flags to write.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             shift_c,
    input  logic             set_flags,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv,
    output logic [3:0]       upd_mask,
    output logic             wb,
    output logic             illegal
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ci;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lres;
    logic             arith;
    logic             test;
    logic             v;
    logic             upd;

    always_comb begin
        x  = a;
        y  = b;
        ci = 1'b0;
        unique case (1'b1)
            (op == OP_SUB) || (op == OP_CMP): begin
                y  = ~b;
                ci = 1'b1;
            end
            op == OP_RSB: begin
                x  = b;
                y  = ~a;
                ci = 1'b1;
            end
            op == OP_ADC: ci = c_in;
            op == OP_SBC: begin
                y  = ~b;
                ci = c_in;
            end
            op == OP_RSC: begin
                x  = b;
                y  = ~a;
                ci = c_in;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    assign v   = (x[WIDTH-1] == y[WIDTH-1]) &&
                 (sum[WIDTH-1] != x[WIDTH-1]);

    always_comb begin
        lres = '0;
        unique case (1'b1)
            (op == OP_AND) || (op == OP_TST): lres = a & b;
            (op == OP_EOR) || (op == OP_TEQ): lres = a ^ b;
            op == OP_ORR: lres = a | b;
            op == OP_MOV: lres = b;
            op == OP_BIC: lres = a & ~b;
            op == OP_MVN: lres = ~b;
            default: ;
        endcase
    end

    assign illegal = op[4];
    assign arith   = is_arith(op);
    assign test    = is_test(op);
    assign wb      = !illegal && !test;
    assign upd     = !illegal && (set_flags || test);

    always_comb begin
        result = '0;
        if (!illegal)
            result = arith ? sum[WIDTH-1:0] : lres;
    end

    always_comb begin
        nzcv        = '0;
        nzcv[FLG_Z] = (result == '0);
        nzcv[FLG_N] = result[WIDTH-1];
        nzcv[FLG_C] = arith ? sum[WIDTH] : shift_c;
        nzcv[FLG_V] = arith ? v : 1'b0;
    end

    // logical ops leave V alone
    always_comb begin
        upd_mask = 4'b0000;
        if (upd)
            upd_mask = arith ? 4'b1111 : 4'b0111;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ARM ALU with valid/ready on both sides.
// Stage A holds the operation; stage B captures the result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         TAG_W      = 4,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_flags,
    input  logic             in_shift_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_wb,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [3:0]       flags
);

    logic             valid_a;
    logic [4:0]       op_a;
    logic [WIDTH-1:0] a_a;
    logic [WIDTH-1:0] b_a;
    logic             s_a;
    logic             shc_a;
    logic [TAG_W-1:0] tag_a;

    logic             adv;
    logic             take;
    logic             move;
    logic [WIDTH-1:0] c_result;
    logic [3:0]       c_nzcv;
    logic [3:0]       c_mask;
    logic             c_wb;
    logic             c_ill;

    assign adv      = !out_valid || out_ready;
    assign in_ready = !valid_a || adv;
    assign take     = in_valid && in_ready && !flush;
    assign move     = adv && valid_a && !flush;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op        (op_a),
        .a         (a_a),
        .b         (b_a),
        .c_in      (flags[FLG_C]),
        .shift_c   (shc_a),
        .set_flags (s_a),
        .result    (c_result),
        .nzcv      (c_nzcv),
        .upd_mask  (c_mask),
        .wb        (c_wb),
        .illegal   (c_ill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_a <= 1'b0;
        end else if (flush) begin
            valid_a <= 1'b0;
        end else if (in_ready) begin
            valid_a <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a  <= '0;
            a_a   <= '0;
            b_a   <= '0;
            s_a   <= 1'b0;
            shc_a <= 1'b0;
            tag_a <= '0;
        end else if (take) begin
            op_a  <= in_op;
            a_a   <= in_a;
            b_a   <= in_b;
            s_a   <= in_set_flags;
            shc_a <= in_shift_c;
            tag_a <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= valid_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_result  <= '0;
            out_wb      <= 1'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (move) begin
            out_result  <= c_result;
            out_wb      <= c_wb;
            out_tag     <= tag_a;
            out_illegal <= c_ill;
        end
    end

    // written as the op leaves A, so ADC/SBC/RSC behind it see its carry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= FLAG_RESET;
        end else if (move) begin
            flags <= (flags & ~c_mask) | (c_nzcv & c_mask);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH=32, TAG_W=4).
// Expected results come from a wide-arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] r;
        logic         wb;
        logic [3:0]   tag;
        logic         ill;
        logic [3:0]   fl;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_set_flags = 1'b0;
    logic         in_shift_c = 1'b0;
    logic [3:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_wb;
    logic [3:0]   out_tag;
    logic         out_illegal;
    logic [3:0]   flags;

    exp_t       q[$];
    logic [3:0] mflags = 4'b0000;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .TAG_W(4), .FLAG_RESET(4'b0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_set_flags (in_set_flags),
        .in_shift_c   (in_shift_c),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_wb       (out_wb),
        .out_tag      (out_tag),
        .out_illegal  (out_illegal),
        .flags        (flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // flags layout: [0]=Z [1]=C [2]=N [3]=V
    function automatic void model(
        input  logic [4:0]   op,
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic         s,
        input  logic         shc,
        input  logic [3:0]   fin,
        output logic [W-1:0] r,
        output logic         wb,
        output logic         ill,
        output logic [3:0]   fo
    );
        logic signed [63:0] sa, sb, sr, cs, ncs;
        logic [63:0] ua, ub, uc, unc;
        logic cf, ar, test;
        fo = fin;
        ill = op[4];
        wb = 1'b0;
        r = '0;
        sr = '0;
        cf = 1'b0;
        ar = 1'b0;
        if (ill) return;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        uc = fin[1] ? 64'd1 : 64'd0;
        unc = 64'd1 - uc;
        cs = $signed(uc);
        ncs = $signed(unc);
        case (op[3:0])
            4'h0, 4'h8: r = a & b;
            4'h1, 4'h9: r = a ^ b;
            4'hC: r = a | b;
            4'hD: r = b;
            4'hE: r = a & ~b;
            4'hF: r = ~b;
            4'h2, 4'hA: begin ar = 1; sr = sa - sb; cf = ua >= ub; end
            4'h3: begin ar = 1; sr = sb - sa; cf = ub >= ua; end
            4'h4, 4'hB: begin
                ar = 1; sr = sa + sb; cf = (ua + ub) > 64'hFFFFFFFF;
            end
            4'h5: begin
                ar = 1; sr = sa + sb + cs;
                cf = (ua + ub + uc) > 64'hFFFFFFFF;
            end
            4'h6: begin ar = 1; sr = sa - sb - ncs; cf = ua >= ub + unc; end
            default: begin ar = 1; sr = sb - sa - ncs; cf = ub >= ua + unc; end
        endcase
        if (ar) r = sr[31:0];
        test = (op[3:2] == 2'b10);
        wb = !test;
        if (s || test) begin
            fo[0] = (r == 0);
            fo[2] = r[31];
            fo[1] = ar ? cf : shc;
            if (ar) fo[3] = (sr != {{32{sr[31]}}, sr[31:0]});
        end
    endfunction

    task automatic send(input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s,
                        input logic shc, input logic [3:0] tag,
                        input bit enq, input bit commit);
        exp_t e;
        logic [3:0] nf;
        int n;
        @(negedge clk);
        in_op = op;
        in_a = a;
        in_b = b;
        in_set_flags = s;
        in_shift_c = shc;
        in_tag = tag;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
        model(op, a, b, s, shc, mflags, e.r, e.wb, e.ill, nf);
        e.tag = tag;
        e.fl = nf;
        if (commit) mflags = nf;
        if (enq) q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {63'b0, out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {32'b0, out_result}, {32'b0, e.r});
                chk("wb_tag_ill", {57'b0, out_wb, out_tag, out_illegal},
                    {57'b0, e.wb, e.tag, e.ill});
                chk("flags", {60'b0, flags}, {60'b0, e.fl});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs", {out_valid, out_wb, out_illegal, out_tag, out_result},
            64'd0);
        chk("rst_flags", {60'b0, flags}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        send(5'b00100, 32'd7, 32'hFFFFFFF9, 1, 0, 4'd1, 1, 1);
        @(negedge clk);
        chk("lat_early", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_two", {63'b0, out_valid}, 64'd1);

        send(5'b00010, 32'h80000000, 32'd1, 1, 0, 4'd2, 1, 1);
        send(5'b01010, 32'd3, 32'd7, 0, 0, 4'd3, 1, 1);
        send(5'b00100, 32'hFFFFFFFF, 32'd1, 1, 0, 4'd4, 1, 1);
        send(5'b00101, 32'd5, 32'd5, 0, 0, 4'd5, 1, 1);
        send(5'b00010, 32'h80000000, 32'd1, 1, 0, 4'd6, 1, 1);
        send(5'b00000, 32'hF0, 32'h0F, 1, 1, 4'd7, 1, 1);
        send(5'b00100, 32'd1, 32'd2, 0, 0, 4'd8, 1, 1);
        send(5'b10110, 32'd9, 32'd9, 1, 1, 4'd9, 1, 1);
        repeat (3) @(negedge clk);

        out_ready = 1'b0;
        send(5'b00100, 32'd10, 32'd1, 1, 0, 4'hA, 1, 1);
        send(5'b00011, 32'd4, 32'd1, 1, 0, 4'hB, 1, 1);
        @(negedge clk);
        in_op = 5'b01111;
        in_a = 32'd0;
        in_b = 32'h0;
        in_set_flags = 1'b1;
        in_shift_c = 1'b0;
        in_tag = 4'hC;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
            chk("stall_out", {27'b0, out_valid, out_tag, out_result},
                {27'b0, 1'b1, q[0].tag, q[0].r});
            @(negedge clk);
        end
        begin
            exp_t e;
            logic [3:0] nf;
            model(in_op, in_a, in_b, 1'b1, 1'b0, mflags, e.r, e.wb, e.ill, nf);
            e.tag = 4'hC;
            e.fl = nf;
            mflags = nf;
            q.push_back(e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_drain", {32'b0, q.size()}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = (i % 4 == 0) ? 32'h7FFFFFFF : $urandom;
            rb = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
            send(5'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'(i), 1, 1);
        end
        repeat (3) @(negedge clk);

        out_ready = 1'b0;
        send(5'b00100, 32'hFFFFFFFF, 32'd1, 1, 0, 4'd1, 0, 1);
        send(5'b01010, 32'd3, 32'd7, 0, 0, 4'd2, 0, 0);
        @(negedge clk);
        chk("flush_full", {63'b0, out_valid}, 64'd1);
        flush = 1'b1;
        in_op = 5'b01010;
        in_a = 32'd1;
        in_b = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_out", {63'b0, out_valid}, 64'd0);
            chk("flush_flags", {60'b0, flags}, {60'b0, mflags});
        end

        out_ready = 1'b0;
        send(5'b00010, 32'd0, 32'd1, 1, 0, 4'd3, 0, 1);
        send(5'b00100, 32'd2, 32'd2, 0, 0, 4'd4, 0, 1);
        chk("pre_rst_flags", {60'b0, flags}, {60'b0, mflags});
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outs",
            {out_valid, out_wb, out_illegal, out_tag, out_result}, 64'd0);
        chk("mid_rst_flags", {60'b0, flags}, 64'd0);
        q.delete();
        mflags = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_ready", {63'b0, in_ready}, 64'd1);
        send(5'b00101, 32'd1, 32'd1, 1, 0, 4'd5, 1, 1);
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        chk("final_drain", {32'b0, q.size()}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
